// File: rtl/bcd_time_counter.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_time_counter
//  Description : Running time-of-day counter, HH:MM:SS.cc in packed BCD.
//                An internal prescaler divides clk down to a hundredths tick.
//                The time is loadable from a 32-bit BCD word; loads are range
//                checked and rejected loads are flagged.
//  Ports       : clk      - system clock, rising edge
//                rst      - synchronous active-high reset
//                run      - 1 = count, 0 = freeze time and prescaler
//                load_en  - single-cycle load request
//                load_bcd - {HH, MM, SS, cc} BCD word to load
//                time_bcd - current time, registered
//                tick     - one-cycle pulse with each hundredth advance
//                day_wrap - one-cycle pulse on 23:59:59.99 -> 00:00:00.00
//                load_err - one-cycle pulse when a load is rejected
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_time_counter #(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int TICK_HZ     = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        load_en,
  input  logic [31:0] load_bcd,
  output logic [31:0] time_bcd,
  output logic        tick,
  output logic        day_wrap,
  output logic        load_err
);

  localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
  localparam int CW  = $clog2(DIV);

  localparam logic [CW-1:0] C_CNT_LAST = CW'(DIV - 1);
  localparam logic [31:0]   C_DAY_LAST = 32'h2359_5999;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   time_q, time_d;
  logic          tick_q, tick_d;
  logic          wrap_q, wrap_d;
  logic          err_q, err_d;

  logic          w_advance;
  logic          w_load_ok;
  logic [31:0]   w_time_inc;

  // A load is legal only if every nibble is a decimal digit and each field
  // is in range; hundredths need no range check beyond the digit check.
  function automatic logic bcd_valid(input logic [31:0] v);
    logic digits_ok;
    digits_ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (v[i*4 +: 4] > 4'd9) digits_ok = 1'b0;
    end
    return digits_ok && (v[31:24] <= 8'h23) && (v[23:16] <= 8'h59) &&
           (v[15:8] <= 8'h59);
  endfunction

  // One-hundredth increment with BCD carries through every field.
  function automatic logic [31:0] bcd_inc(input logic [31:0] t);
    logic [31:0] r;
    r = t;
    if (t[3:0] != 4'd9) begin
      r[3:0] = t[3:0] + 4'd1;
    end else begin
      r[3:0] = 4'd0;
      if (t[7:4] != 4'd9) begin
        r[7:4] = t[7:4] + 4'd1;
      end else begin
        r[7:4] = 4'd0;
        // seconds
        if (t[11:8] != 4'd9) begin
          r[11:8] = t[11:8] + 4'd1;
        end else begin
          r[11:8] = 4'd0;
          if (t[15:12] != 4'd5) begin
            r[15:12] = t[15:12] + 4'd1;
          end else begin
            r[15:12] = 4'd0;
            // minutes
            if (t[19:16] != 4'd9) begin
              r[19:16] = t[19:16] + 4'd1;
            end else begin
              r[19:16] = 4'd0;
              if (t[23:20] != 4'd5) begin
                r[23:20] = t[23:20] + 4'd1;
              end else begin
                r[23:20] = 4'd0;
                // hours: 23 wraps to 00, otherwise ordinary BCD increment
                if (t[31:24] == 8'h23) begin
                  r[31:24] = 8'h00;
                end else if (t[27:24] != 4'd9) begin
                  r[27:24] = t[27:24] + 4'd1;
                end else begin
                  r[27:24] = 4'd0;
                  r[31:28] = t[31:28] + 4'd1;
                end
              end
            end
          end
        end
      end
    end
    return r;
  endfunction

  assign w_advance  = run && (cnt_q == C_CNT_LAST);
  assign w_load_ok  = load_en && bcd_valid(load_bcd);
  assign w_time_inc = bcd_inc(time_q);

  always_comb begin
    cnt_d  = cnt_q;
    time_d = time_q;
    tick_d = 1'b0;
    wrap_d = 1'b0;
    err_d  = load_en && !w_load_ok;

    if (w_load_ok) begin
      // A valid load overrides any coincident advance and restarts the
      // prescaler so a full period elapses before the next tick.
      time_d = load_bcd;
      cnt_d  = '0;
    end else if (run) begin
      if (w_advance) begin
        cnt_d  = '0;
        time_d = w_time_inc;
        tick_d = 1'b1;
        wrap_d = (time_q == C_DAY_LAST);
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      time_q <= 32'h0000_0000;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      time_q <= time_d;
      tick_q <= tick_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign time_bcd = time_q;
  assign tick     = tick_q;
  assign day_wrap = wrap_q;
  assign load_err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_time_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_time_counter
//  Description : Self-checking bench for bcd_time_counter with DIV = 10.
//                Table of load vectors plus directed multi-cycle sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_time_counter;

  logic        clk;
  logic        rst;
  logic        run;
  logic        load_en;
  logic [31:0] load_bcd;
  logic [31:0] time_bcd;
  logic        tick;
  logic        day_wrap;
  logic        load_err;

  int n_cmp;
  int n_bad;

  bcd_time_counter #(
    .CLK_FREQ_HZ(1000),
    .TICK_HZ    (100)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
    .load_en (load_en),
    .load_bcd(load_bcd),
    .time_bcd(time_bcd),
    .tick    (tick),
    .day_wrap(day_wrap),
    .load_err(load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ld;
    logic        valid;
    logic [31:0] next_t;
    logic        wrap;
  } vec_t;

  vec_t vecs[10];

  // Advance one clock; inputs change and outputs are sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_load(input logic [31:0] v);
    load_en  = 1'b1;
    load_bcd = v;
    step();
    load_en  = 1'b0;
  endtask

  // Steps until tick is seen (bounded) and checks it took exactly exp_n steps.
  task automatic wait_tick(input string name, input int exp_n);
    int n;
    n = 0;
    for (int i = 1; i <= exp_n + 5; i++) begin
      step();
      n = i;
      if (tick) break;
    end
    if (!tick) n = -1;
    check(name, 32'(n), 32'(exp_n));
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    rst      = 1'b1;
    run      = 1'b1;
    load_en  = 1'b0;
    load_bcd = 32'h0;

    //           load          valid  next time      wrap
    vecs[0] = '{32'h0000_0009, 1'b1, 32'h0000_0010, 1'b0};
    vecs[1] = '{32'h0000_5999, 1'b1, 32'h0001_0000, 1'b0};
    vecs[2] = '{32'h2359_5999, 1'b1, 32'h0000_0000, 1'b1};
    vecs[3] = '{32'h0959_5999, 1'b1, 32'h1000_0000, 1'b0};
    vecs[4] = '{32'h1959_5999, 1'b1, 32'h2000_0000, 1'b0};
    vecs[5] = '{32'h2400_0000, 1'b0, 32'h0,         1'b0};
    vecs[6] = '{32'h0060_0000, 1'b0, 32'h0,         1'b0};
    vecs[7] = '{32'h0000_000A, 1'b0, 32'h0,         1'b0};
    vecs[8] = '{32'h0000_6000, 1'b0, 32'h0,         1'b0};
    vecs[9] = '{32'h0A00_0000, 1'b0, 32'h0,         1'b0};

    // ---------------- reset ----------------
    step();
    step();
    check("reset time", time_bcd, 32'h0);
    check("reset tick", {31'b0, tick}, 32'h0);
    check("reset flags", {30'b0, day_wrap, load_err}, 32'h0);
    rst = 1'b0;
    wait_tick("first tick latency", 10);
    check("first tick time", time_bcd, 32'h0000_0001);

    // ---------------- table-driven loads ----------------
    for (int k = 0; k < 10; k++) begin
      if (vecs[k].valid) begin
        do_load(vecs[k].ld);
        check($sformatf("v%0d load time", k), time_bcd, vecs[k].ld);
        check($sformatf("v%0d load err", k), {31'b0, load_err}, 32'h0);
        wait_tick($sformatf("v%0d tick latency", k), 10);
        check($sformatf("v%0d next time", k), time_bcd, vecs[k].next_t);
        check($sformatf("v%0d wrap", k), {31'b0, day_wrap}, {31'b0, vecs[k].wrap});
        wait_tick($sformatf("v%0d 2nd tick latency", k), 10);
        check($sformatf("v%0d 2nd wrap", k), {31'b0, day_wrap}, 32'h0);
      end else begin
        // Base load, 3 cycles into the period, then the rejected load.
        do_load(32'h0102_0300);
        step();
        step();
        step();
        do_load(vecs[k].ld);
        check($sformatf("v%0d err pulse", k), {31'b0, load_err}, 32'h1);
        check($sformatf("v%0d time kept", k), time_bcd, 32'h0102_0300);
        step();
        check($sformatf("v%0d err one cycle", k), {31'b0, load_err}, 32'h0);
        wait_tick($sformatf("v%0d uninterrupted", k), 5);
        check($sformatf("v%0d time after", k), time_bcd, 32'h0102_0301);
      end
    end

    // ---------------- valid load in the advance cycle ----------------
    do_load(32'h1234_0000);
    for (int i = 0; i < 9; i++) step();
    do_load(32'h1234_5600);
    check("collide time", time_bcd, 32'h1234_5600);
    check("collide no tick", {31'b0, tick}, 32'h0);
    wait_tick("collide next latency", 10);
    check("collide next time", time_bcd, 32'h1234_5601);

    // ---------------- invalid load in the advance cycle ----------------
    do_load(32'h0000_0099);
    for (int i = 0; i < 9; i++) step();
    do_load(32'h0000_00A0);
    check("inv collide tick", {31'b0, tick}, 32'h1);
    check("inv collide err", {31'b0, load_err}, 32'h1);
    check("inv collide time", time_bcd, 32'h0000_0100);

    // ---------------- freeze ----------------
    do_load(32'h0500_0000);
    for (int i = 0; i < 4; i++) step();
    run = 1'b0;
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 25; i++) begin
        step();
        if (tick || time_bcd !== 32'h0500_0000) seen++;
      end
      check("freeze stable", 32'(seen), 32'h0);
    end
    run = 1'b1;
    wait_tick("resume latency", 6);
    check("resume time", time_bcd, 32'h0500_0001);

    // ---------------- load while frozen resets prescaler ----------------
    for (int i = 0; i < 5; i++) step();
    run = 1'b0;
    do_load(32'h0700_0000);
    check("frozen load time", time_bcd, 32'h0700_0000);
    run = 1'b1;
    wait_tick("frozen load latency", 10);

    // ---------------- reset mid-count ----------------
    for (int i = 0; i < 6; i++) step();
    rst = 1'b1;
    step();
    check("mid reset time", time_bcd, 32'h0);
    rst = 1'b0;
    wait_tick("post reset latency", 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
